riscv_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit for the 5-stage core's execute stage. It accepts one M-extension operation from E and computes it over multiple cycles. While it works it raises a stall that the hazard unit ORs into the F/D/E stall terms, then delivers a registered result that E forwards into the E/M register. Width and multiplier step size are parametrised so the same block serves XLEN=32/64 and trades area for latency.

---
 rtl/riscv_muldiv.sv | 109 ++++++++++
 tb/tb_riscv_muldiv.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_muldiv.sv
// riscv_muldiv: iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Shift-add multiply (MUL_UNROLL bits/cycle) and restoring divide (1 bit/cycle) on magnitudes.
module riscv_muldiv #(
  parameter int XLEN       = 32,
  parameter int MUL_UNROLL = 1
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_valid,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_kill,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);
  localparam int CW = $clog2(XLEN + 1);
  localparam int U = MUL_UNROLL;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] b_q, b_d, res_q, res_d;
  logic [2:0] op_q, op_d;
  logic s1_q, s1_d, s2_q, s2_d;
  logic neg1, neg2, div0, ovf, last, ge;
  logic [XLEN-1:0] mag1, mag2, spec_val, quo, rem, fin;
  logic [XLEN+U-1:0] mulp, msum;
  logic [XLEN:0] rem_sh;
  logic [2*XLEN-1:0] mul_next, div_next, step, pn;
  // rs1 signed for MULH/MULHSU/DIV/REM, rs2 signed for MULH/DIV/REM
  assign neg1 = (i_op[2] ? ~i_op[0] : (i_op[1] ^ i_op[0])) & i_rs1[XLEN-1];
  assign neg2 = (i_op[2] ? ~i_op[0] : (i_op[1:0] == 2'b01)) & i_rs2[XLEN-1];
  assign mag1 = neg1 ? -i_rs1 : i_rs1;
  assign mag2 = neg2 ? -i_rs2 : i_rs2;
  assign div0 = i_op[2] & (i_rs2 == '0);
  assign ovf = i_op[2] & ~i_op[0] & (i_rs1 == MIN) & (&i_rs2);
  assign spec_val = div0 ? (i_op[1] ? i_rs1 : '1) : (i_op[1] ? '0 : i_rs1);
  // multiply: acc = {partial high, remaining multiplier}, shifted right U bits per step
  assign mulp = {{U{1'b0}}, b_q} * {{XLEN{1'b0}}, acc_q[U-1:0]};
  assign msum = {{U{1'b0}}, acc_q[2*XLEN-1:XLEN]} + mulp;
  assign mul_next = {msum, acc_q[XLEN-1:U]};
  // divide: acc = {partial remainder, dividend/quotient}
  assign rem_sh = acc_q[2*XLEN-1:XLEN-1];
  assign ge = rem_sh >= {1'b0, b_q};
  assign div_next = {ge ? rem_sh[XLEN-1:0] - b_q : rem_sh[XLEN-1:0], acc_q[XLEN-2:0], ge};
  assign step = op_q[2] ? div_next : mul_next;
  assign last = cnt_q == (op_q[2] ? CW'(XLEN - 1) : CW'(XLEN / U - 1));
  assign pn = (s1_q ^ s2_q) ? -step : step;
  assign quo = (s1_q ^ s2_q) ? -step[XLEN-1:0] : step[XLEN-1:0];
  assign rem = s1_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
  assign fin = !op_q[2] ? ((op_q[1:0] == 2'b00) ? pn[XLEN-1:0] : pn[2*XLEN-1:XLEN])
                        : (op_q[1] ? rem : quo);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    b_d = b_q;
    op_d = op_q;
    s1_d = s1_q;
    s2_d = s2_q;
    res_d = res_q;
    if (i_kill) begin
      state_d = IDLE;
    end else if (state_q == IDLE && i_valid) begin
      op_d = i_op;
      s1_d = neg1;
      s2_d = neg2;
      b_d = mag2;
      acc_d = {{XLEN{1'b0}}, mag1};
      cnt_d = '0;
      state_d = (div0 | ovf) ? DONE : CALC;
      res_d = (div0 | ovf) ? spec_val : res_q;
    end else if (state_q == CALC) begin
      acc_d = step;
      cnt_d = cnt_q + CW'(1);
      state_d = last ? DONE : CALC;
      res_d = last ? fin : res_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      b_q <= '0;
      op_q <= '0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      b_q <= b_d;
      op_q <= op_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      res_q <= res_d;
    end
  end
  assign o_stall = (state_q == IDLE && i_valid && !i_kill) || state_q == CALC;
  assign o_valid = state_q == DONE;
  assign o_result = res_q;
endmodule

// File: tb/tb_riscv_muldiv.sv
// tb_riscv_muldiv: directed and randomized checks of riscv_muldiv on three configurations
// (XLEN=32/UNROLL=1, XLEN=32/UNROLL=4, XLEN=64/UNROLL=4) against an arithmetic reference model.
module tb_riscv_muldiv;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic kill = 1'b0;
  logic [2:0] v = '0;
  logic [2:0] op = '0;
  logic [63:0] rs1 = '0, rs2 = '0;
  logic [2:0] ov, os;
  logic [31:0] r0, r1;
  logic [63:0] r2;
  logic [63:0] res [3];
  logic [63:0] last_exp [3];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  riscv_muldiv #(.XLEN(32), .MUL_UNROLL(1)) d0 (.i_clk(clk), .i_rstn(rstn), .i_valid(v[0]), .i_op(op),
    .i_rs1(rs1[31:0]), .i_rs2(rs2[31:0]), .i_kill(kill), .o_stall(os[0]), .o_valid(ov[0]), .o_result(r0));
  riscv_muldiv #(.XLEN(32), .MUL_UNROLL(4)) d1 (.i_clk(clk), .i_rstn(rstn), .i_valid(v[1]), .i_op(op),
    .i_rs1(rs1[31:0]), .i_rs2(rs2[31:0]), .i_kill(kill), .o_stall(os[1]), .o_valid(ov[1]), .o_result(r1));
  riscv_muldiv #(.XLEN(64), .MUL_UNROLL(4)) d2 (.i_clk(clk), .i_rstn(rstn), .i_valid(v[2]), .i_op(op),
    .i_rs1(rs1), .i_rs2(rs2), .i_kill(kill), .o_stall(os[2]), .o_valid(ov[2]), .o_result(r2));
  assign res[0] = {32'b0, r0};
  assign res[1] = {32'b0, r1};
  assign res[2] = r2;
  function automatic int xlen_of(input int idx);
    return idx == 2 ? 64 : 32;
  endfunction
  function automatic logic [63:0] mask_of(input int idx);
    return idx == 2 ? '1 : 64'h0000_0000_FFFF_FFFF;
  endfunction
  // RISC-V M semantics from wide signed/unsigned arithmetic
  function automatic logic [63:0] model(input int idx, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] as, bs, au, bu, r;
    int xl;
    xl = xlen_of(idx);
    au = {66'b0, a & mask_of(idx)};
    bu = {66'b0, b & mask_of(idx)};
    as = xl == 64 ? {{66{a[63]}}, a} : {{98{a[31]}}, a[31:0]};
    bs = xl == 64 ? {{66{b[63]}}, b} : {{98{b[31]}}, b[31:0]};
    if (o[2] && bu == 0) r = o[1] ? au : '1;
    else
      case (o)
        3'd0: r = as * bs;
        3'd1: r = (as * bs) >>> xl;
        3'd2: r = (as * bu) >>> xl;
        3'd3: r = (au * bu) >> xl;
        3'd4: r = as / bs;
        3'd5: r = au / bu;
        3'd6: r = as % bs;
        default: r = au % bu;
      endcase
    return r[63:0] & mask_of(idx);
  endfunction
  function automatic int lat(input int idx, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m, mn;
    logic special;
    m = mask_of(idx);
    mn = idx == 2 ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
    special = o[2] && ((b & m) == 0 || (!o[0] && (a & m) == mn && (b & m) == m));
    if (special) return 1;
    return o[2] ? xlen_of(idx) + 1 : xlen_of(idx) / (idx == 0 ? 1 : 4) + 1;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input int idx, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    v = '0;
    v[idx] = 1'b1;
    op = o;
    rs1 = a;
    rs2 = b;
    kill = 1'b0;
  endtask
  // accept in the cycle after the call; o_valid cycle is measured from the accept cycle
  task automatic run(input int idx, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input string tag);
    int n;
    logic bad, done;
    @(negedge clk);
    drive(idx, o, a, b);
    #1;
    n = 0;
    bad = 1'b0;
    done = 1'b0;
    while (!done && n < 300) begin
      if (ov[idx]) done = 1'b1;
      else begin
        bad |= !os[idx];
        @(negedge clk);
        #1;
        n++;
      end
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat(idx, o, a, b)));
    chk({tag, "_stall_hi"}, {63'b0, bad}, 64'b0);
    chk({tag, "_stall_lo"}, {63'b0, os[idx]}, 64'b0);
    chk({tag, "_res"}, res[idx], exp & mask_of(idx));
    last_exp[idx] = exp & mask_of(idx);
  endtask
  initial begin
    logic seen;
    int idx;
    logic [2:0] o;
    logic [63:0] a, b;
    for (int i = 0; i < 3; i++) last_exp[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_res", res[i], 64'b0);
      chk("rst_valid", {63'b0, ov[i]}, 64'b0);
      chk("rst_stall", {63'b0, os[i]}, 64'b0);
    end
    rstn = 1'b1;
    run(0, 3'd0, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, "mul");
    run(0, 3'd1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, "mulh");
    run(0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, "mulhu");
    run(0, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "mulhsu");
    run(0, 3'd4, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, "div");
    run(0, 3'd6, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, "rem");
    run(0, 3'd5, 64'd100, 64'd7, 64'd14, "divu");
    run(0, 3'd7, 64'd100, 64'd7, 64'd2, "remu");
    run(0, 3'd4, 64'd5, 64'd0, 64'hFFFF_FFFF, "div0");
    run(0, 3'd7, 64'd5, 64'd0, 64'd5, "remu0");
    run(0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, "div_ovf");
    run(0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, "rem_ovf");
    run(1, 3'd0, 64'h1234_5678, 64'h10, 64'h2345_6780, "mul_u4");
    run(2, 3'd5, 64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, "divu64");
    // kill mid-divide: no o_valid, result held, back to IDLE
    @(negedge clk);
    drive(0, 3'd5, 64'd1000, 64'd7);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      #1;
      seen |= ov[0];
    end
    kill = 1'b1;
    v = '0;
    @(posedge clk);
    #1;
    kill = 1'b0;
    #1;
    chk("kill_no_valid", {63'b0, seen | ov[0]}, 64'b0);
    chk("kill_idle", {63'b0, os[0]}, 64'b0);
    chk("kill_res_held", res[0], last_exp[0]);
    run(0, 3'd0, 64'd3, 64'd4, 64'd12, "mul_after_kill");
    // reset mid-divide
    @(negedge clk);
    drive(0, 3'd5, 64'd1000, 64'd7);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      #1;
      seen |= ov[0];
    end
    v = '0;
    rstn = 1'b0;
    #1;
    chk("rstmid_res", res[0], 64'b0);
    chk("rstmid_no_valid", {63'b0, seen | ov[0]}, 64'b0);
    chk("rstmid_idle", {63'b0, os[0]}, 64'b0);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) last_exp[i] = '0;
    run(0, 3'd0, 64'd3, 64'd4, 64'd12, "mul_after_rst");
    // randomized back-to-back operations with corner-biased operands
    for (int k = 0; k < 60; k++) begin
      idx = int'($urandom_range(0, 2));
      o = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: begin a = idx == 2 ? 64'h8000_0000_0000_0000 : 64'h8000_0000; b = '1; end
        3: b = 64'($urandom_range(1, 15));
        default: ;
      endcase
      a &= mask_of(idx);
      b &= mask_of(idx);
      run(idx, o, a, b, model(idx, o, a, b), $sformatf("rnd%0d_op%0d", k, o));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
